pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/mips_pkg.sv | 13 +
 rtl/load_use_detect.sv | 25 ++
 rtl/pipeline_ctrl.sv | 113 +++++++++++
 tb/tb_pipeline_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline-control constants: FSM state encoding, the memory-wait
// ceiling, and the hardwired-zero register index.
package mips_pkg;

  typedef logic [0:0] ctrl_state_t;

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [7:0] WAIT_MAX = 8'd255;
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID-stage instruction that reads the destination of a load still in EX.
module load_use_detect
  import mips_pkg::*;
(
  input  logic [4:0] rs_ID,
  input  logic [4:0] rt_ID,
  input  logic       use_rs_ID,
  input  logic       use_rt_ID,
  input  logic [4:0] wreg_EX,
  input  logic       RegWrite_EX,
  input  logic       MemtoReg_EX,
  output logic       hazard
);

  logic rs_match;
  logic rt_match;

  assign rs_match = use_rs_ID && (rs_ID == wreg_EX);
  assign rt_match = use_rt_ID && (rt_ID == wreg_EX);

  // Writes to r0 are discarded, so a load into r0 never creates a dependency.
  assign hazard = MemtoReg_EX && RegWrite_EX && (wreg_EX != REG_ZERO) &&
                  (rs_match || rt_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, EX redirects and
// data-memory wait states, with stall-cycle and memory-timeout bookkeeping.
module pipeline_ctrl
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_ID,
  input  logic [4:0]  rt_ID,
  input  logic        use_rs_ID,
  input  logic        use_rt_ID,
  input  logic [4:0]  wreg_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        redirect_EX,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_PC,
  output logic        stall_IF_ID,
  output logic        stall_ID_EX,
  output logic        stall_EX_MEM,
  output logic        stall_MEM_WB,
  output logic        clear_IF_ID,
  output logic        clear_ID_EX,
  output logic        clear_MEM_WB,
  output logic [15:0] stall_cycles,
  output logic        mem_timeout
);

  ctrl_state_t state;
  logic [7:0]  wait_cnt;
  logic        hazard;
  logic        mem_stall;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == WAIT_MAX) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  load_use_detect u_load_use_detect (
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .use_rs_ID   (use_rs_ID),
    .use_rt_ID   (use_rt_ID),
    .wreg_EX     (wreg_EX),
    .RegWrite_EX (RegWrite_EX),
    .MemtoReg_EX (MemtoReg_EX),
    .hazard      (hazard)
  );

  // In MEM_WAIT only readiness matters; dmem_req is assumed held by MEM.
  assign mem_stall = (state == MEM_WAIT) ? !dmem_ready : (dmem_req && !dmem_ready);

  always_comb begin
    stall_PC     = 1'b1;
    stall_IF_ID  = 1'b1;
    stall_ID_EX  = 1'b1;
    stall_EX_MEM = 1'b1;
    stall_MEM_WB = 1'b1;
    clear_IF_ID  = 1'b0;
    clear_ID_EX  = 1'b0;
    clear_MEM_WB = 1'b0;
    // Reset gates the outputs directly so defaults appear without waiting for a clock.
    if (!rst) begin
      if (mem_stall) begin
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        stall_ID_EX  = 1'b0;
        stall_EX_MEM = 1'b0;
        stall_MEM_WB = 1'b0;
        clear_MEM_WB = 1'b1;
      end else if (redirect_EX) begin
        clear_IF_ID  = 1'b1;
        clear_ID_EX  = 1'b1;
      end else if (hazard) begin
        stall_PC     = 1'b0;
        stall_IF_ID  = 1'b0;
        clear_ID_EX  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      stall_cycles <= 16'd0;
      mem_timeout  <= 1'b0;
    end else begin
      if (state == RUN) begin
        if (mem_stall) begin
          state    <= MEM_WAIT;
          wait_cnt <= 8'd1;
        end
      end else begin
        if (dmem_ready) begin
          state    <= RUN;
          wait_cnt <= 8'd0;
        end else begin
          wait_cnt <= sat_inc8(wait_cnt);
          if (wait_cnt == WAIT_MAX - 8'd1)
            mem_timeout <= 1'b1;
        end
      end
      if (!stall_PC)
        stall_cycles <= sat_inc16(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: each stimulus cycle queues its
// expected control vector, which is popped and compared mid-cycle.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_ID, rt_ID, wreg_EX;
  logic        use_rs_ID, use_rt_ID, RegWrite_EX, MemtoReg_EX;
  logic        redirect_EX, dmem_req, dmem_ready;
  logic        stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB;
  logic        clear_IF_ID, clear_ID_EX, clear_MEM_WB;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  int checks   = 0;
  int failures = 0;

  // {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB, clear_IF_ID, clear_ID_EX, clear_MEM_WB}
  localparam logic [7:0] EXP_DEF = 8'b11111_000;
  localparam logic [7:0] EXP_LU  = 8'b00111_010;
  localparam logic [7:0] EXP_RD  = 8'b11111_110;
  localparam logic [7:0] EXP_MEM = 8'b00000_001;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .rs_ID        (rs_ID),
    .rt_ID        (rt_ID),
    .use_rs_ID    (use_rs_ID),
    .use_rt_ID    (use_rt_ID),
    .wreg_EX      (wreg_EX),
    .RegWrite_EX  (RegWrite_EX),
    .MemtoReg_EX  (MemtoReg_EX),
    .redirect_EX  (redirect_EX),
    .dmem_req     (dmem_req),
    .dmem_ready   (dmem_ready),
    .stall_PC     (stall_PC),
    .stall_IF_ID  (stall_IF_ID),
    .stall_ID_EX  (stall_ID_EX),
    .stall_EX_MEM (stall_EX_MEM),
    .stall_MEM_WB (stall_MEM_WB),
    .clear_IF_ID  (clear_IF_ID),
    .clear_ID_EX  (clear_ID_EX),
    .clear_MEM_WB (clear_MEM_WB),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout)
  );

  function automatic logic [7:0] outs();
    return {stall_PC, stall_IF_ID, stall_ID_EX, stall_EX_MEM, stall_MEM_WB,
            clear_IF_ID, clear_ID_EX, clear_MEM_WB};
  endfunction

  task automatic idle_inputs();
    rs_ID = 5'd0; rt_ID = 5'd0; wreg_EX = 5'd0;
    use_rs_ID = 1'b0; use_rt_ID = 1'b0; RegWrite_EX = 1'b0; MemtoReg_EX = 1'b0;
    redirect_EX = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rs, input logic [4:0] rt,
                              input logic urs, input logic urt, input logic [4:0] wreg);
    rs_ID = rs; rt_ID = rt; use_rs_ID = urs; use_rt_ID = urt;
    wreg_EX = wreg; RegWrite_EX = 1'b1; MemtoReg_EX = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [7:0] got, e;
    rst = 1'b1;
    set_load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
    redirect_EX = 1'b1; dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(EXP_DEF);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", got, e); end
      checks++;
      if (stall_cycles !== 16'd0 || mem_timeout !== 1'b0) begin
        failures++; $display("FAIL reset_counters got sc=%0d to=%b exp sc=0 to=0", stall_cycles, mem_timeout);
      end
    end
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    logic [7:0] got, e;
    logic [7:0] exp_tbl[4];
    exp_tbl = '{EXP_LU, EXP_DEF, EXP_LU, EXP_DEF};
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i == 0) set_load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
      if (i == 2) set_load_use(5'd3, 5'd7, 1'b1, 1'b1, 5'd7);
      exp_q.push_back(exp_tbl[i]);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL load_use[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
      if (i == 1 || i == 3) begin
        checks++;
        if (stall_cycles !== 16'((i + 1) / 2)) begin
          failures++; $display("FAIL load_use_count[%0d] got=%0d exp=%0d", i, stall_cycles, (i + 1) / 2);
        end
      end
    end
  endtask

  task automatic test_no_hazard();
    logic [7:0] got, e;
    logic [15:0] sc0;
    sc0 = stall_cycles;
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      case (i)
        0: set_load_use(5'd0, 5'd0, 1'b1, 1'b0, 5'd0);
        1: set_load_use(5'd5, 5'd0, 1'b0, 1'b0, 5'd5);
        2: begin set_load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); MemtoReg_EX = 1'b0; end
        default: set_load_use(5'd5, 5'd6, 1'b1, 1'b1, 5'd9);
      endcase
      exp_q.push_back(EXP_DEF);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL no_hazard[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cycles !== sc0) begin failures++; $display("FAIL no_hazard_count got=%0d exp=%0d", stall_cycles, sc0); end
  endtask

  task automatic test_redirect();
    logic [7:0] got, e;
    logic [15:0] sc0;
    sc0 = stall_cycles;
    set_load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
    redirect_EX = 1'b1;
    exp_q.push_back(EXP_RD);
    @(negedge clk);
    got = outs(); e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL redirect_over_lu got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (stall_cycles !== sc0) begin failures++; $display("FAIL redirect_count got=%0d exp=%0d", stall_cycles, sc0); end
  endtask

  task automatic test_mem_ready_same_cycle();
    logic [7:0] got, e;
    set_load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
    dmem_req = 1'b1; dmem_ready = 1'b1;
    exp_q.push_back(EXP_LU);
    @(negedge clk);
    got = outs(); e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL mem_ready_lu got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_mem_wait();
    logic [7:0] got, e;
    logic [15:0] sc0;
    logic [7:0] exp_tbl[6];
    exp_tbl = '{EXP_MEM, EXP_MEM, EXP_MEM, EXP_RD, EXP_DEF, EXP_DEF};
    sc0 = stall_cycles;
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      dmem_req = (i < 4);
      dmem_ready = (i == 3);
      redirect_EX = (i == 1 || i == 3);
      if (i == 2) set_load_use(5'd5, 5'd0, 1'b1, 1'b0, 5'd5);
      exp_q.push_back(exp_tbl[i]);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL mem_wait[%0d] got=%b exp=%b", i, got, e); end
      @(posedge clk); #1;
    end
    idle_inputs();
    checks++;
    if (stall_cycles !== sc0 + 16'd3) begin
      failures++; $display("FAIL mem_wait_count got=%0d exp=%0d", stall_cycles, sc0 + 16'd3);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] got, e;
    int to_errs;
    do_reset();
    to_errs = 0;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      exp_q.push_back(EXP_MEM);
      @(negedge clk);
      got = outs(); e = exp_q.pop_front();
      checks++;
      if (got !== e) begin failures++; $display("FAIL timeout_wait[%0d] got=%b exp=%b", k, got, e); end
      checks++;
      if (mem_timeout !== (k >= 256)) begin
        failures++; $display("FAIL timeout_flag[%0d] got=%b exp=%b", k, mem_timeout, k >= 256);
      end
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1;
    exp_q.push_back(EXP_DEF);
    @(negedge clk);
    got = outs(); e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL timeout_done got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    idle_inputs();
    checks++;
    if (stall_cycles !== 16'd300 || mem_timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_final got sc=%0d to=%b exp sc=300 to=1", stall_cycles, mem_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] got, e;
    dmem_req = 1'b1; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.push_back(EXP_DEF);
    got = outs(); e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL rst_mid_wait_out got=%b exp=%b", got, e); end
    checks++;
    if (stall_cycles !== 16'd0 || mem_timeout !== 1'b0) begin
      failures++; $display("FAIL rst_mid_wait_cnt got sc=%0d to=%b exp sc=0 to=0", stall_cycles, mem_timeout);
    end
    dmem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // Ready still low: a leftover MEM_WAIT would show a memory stall here.
    exp_q.push_back(EXP_DEF);
    #1;
    got = outs(); e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL rst_resume_run got=%b exp=%b", got, e); end
    @(posedge clk); #1;
    dmem_req = 1'b1;
    exp_q.push_back(EXP_MEM);
    @(negedge clk);
    got = outs(); e = exp_q.pop_front();
    checks++;
    if (got !== e) begin failures++; $display("FAIL rst_new_wait got=%b exp=%b", got, e); end
    idle_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #1;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_redirect();
    test_mem_ready_same_cycle();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
